// File: rtl/video_fetch_responder_if.sv
// Purpose: bundles the fetcher bus (cyc/adr/ack/dat) and the video SRAM pins.
// Latency: none, wires only.
// Backpressure: none; the fetcher holds cyc_i until it sees ack_o.
//
// Modports:
//   slave  - the responder: takes cyc_i/adr_i/sram_dat_i, drives ack_o/dat_o and the SRAM strobes
//   master - the environment (fetcher plus SRAM): the opposite directions
interface video_fetch_responder_if;
    logic        cyc_i;
    logic [23:1] adr_i;
    logic        ack_o;
    logic [15:0] dat_o;
    logic [23:1] sram_adr_o;
    logic        sram_ce_no;
    logic        sram_oe_no;
    logic [15:0] sram_dat_i;

    modport slave (
        input  cyc_i, adr_i, sram_dat_i,
        output ack_o, dat_o, sram_adr_o, sram_ce_no, sram_oe_no
    );

    modport master (
        output cyc_i, adr_i, sram_dat_i,
        input  ack_o, dat_o, sram_adr_o, sram_ce_no, sram_oe_no
    );
endinterface

// File: rtl/video_fetch_responder.sv
// Purpose: serves framebuffer word reads from asynchronous video SRAM with programmable wait states.
// Latency: ack WAIT_STATES+1 edges after cyc_i is sampled; period WAIT_STATES+3 (WAIT_STATES+2 when predicting).
// Backpressure: the fetcher stalls on cyc_i until ack_o; dropping cyc_i aborts the word in flight.
//
// Ports: clk_i, reset_ni (async, active low); bus (slave modport) carries the fetcher
// cyc_i/adr_i/ack_o/dat_o and the SRAM sram_adr_o/sram_ce_no/sram_oe_no/sram_dat_i.
// Optional feature: define VIDEO_FETCH_PREDICT_EN for back-to-back address prediction.
module video_fetch_responder #(
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    video_fetch_responder_if.slave  bus
);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t      state_q, state_d;
    logic [3:0]  wcnt_q,  wcnt_d;
    logic [23:1] adr_q,   adr_d;
    logic [15:0] dat_q,   dat_d;
    logic        ack_q,   ack_d;
`ifdef VIDEO_FETCH_PREDICT_EN
    // Set while the current ACCESS was launched from a guessed address and
    // has not yet been checked against what the fetcher actually presents.
    logic        pred_q,  pred_d;
`endif

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            wcnt_q  <= 4'd0;
            adr_q   <= '0;
            dat_q   <= 16'd0;
            ack_q   <= 1'b0;
`ifdef VIDEO_FETCH_PREDICT_EN
            pred_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
`ifdef VIDEO_FETCH_PREDICT_EN
            pred_q  <= pred_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        ack_d   = 1'b0;
`ifdef VIDEO_FETCH_PREDICT_EN
        pred_d  = pred_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.cyc_i) begin
                    adr_d   = bus.adr_i;
                    wcnt_d  = WS;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
`ifdef VIDEO_FETCH_PREDICT_EN
                pred_d = 1'b0;
`endif
                if (!bus.cyc_i) begin
                    // Fetcher gave up (or the line ended under a speculative
                    // access): drop the word without acknowledging it.
                    state_d = IDLE;
`ifdef VIDEO_FETCH_PREDICT_EN
                end else if (pred_q && (bus.adr_i != adr_q)) begin
                    // Guess was wrong (e.g. vsync reload): restart the access
                    // at the real address with a full wait count.
                    adr_d  = bus.adr_i;
                    wcnt_d = WS;
`endif
                end else if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else begin
                    dat_d   = bus.sram_dat_i;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
`ifdef VIDEO_FETCH_PREDICT_EN
                // The fetcher steps adr_i at this same edge, so the next word
                // is almost always adr_i+1; start fetching it right away.
                if (bus.cyc_i) begin
                    adr_d   = bus.adr_i + 23'd1;
                    wcnt_d  = WS;
                    pred_d  = 1'b1;
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are a pure function of state so reset releases them at once.
    assign bus.sram_ce_no = (state_q == IDLE);
    assign bus.sram_oe_no = (state_q == IDLE);
    assign bus.sram_adr_o = adr_q;
    assign bus.ack_o      = ack_q;
    assign bus.dat_o      = dat_q;
endmodule

// File: tb/tb_video_fetch_responder.sv
module tb_video_fetch_responder;
    logic        clk;
    logic        reset_ni;
    logic        cyc;
    logic [23:1] adr;
    logic        sel;          // 0: WAIT_STATES=2 instance, 1: WAIT_STATES=0 instance
    int          cnt;
    int          total;
    int          bad;

    video_fetch_responder_if if2 ();
    video_fetch_responder_if if0 ();

    video_fetch_responder #(.WAIT_STATES(2)) u_dut2 (.clk_i(clk), .reset_ni(reset_ni), .bus(if2.slave));
    video_fetch_responder #(.WAIT_STATES(0)) u_dut0 (.clk_i(clk), .reset_ni(reset_ni), .bus(if0.slave));

    // SRAM model: each word holds the low 16 bits of its own word address.
    assign if2.cyc_i      = cyc & ~sel;
    assign if0.cyc_i      = cyc & sel;
    assign if2.adr_i      = adr;
    assign if0.adr_i      = adr;
    assign if2.sram_dat_i = if2.sram_adr_o[16:1];
    assign if0.sram_dat_i = if0.sram_adr_o[16:1];

    logic        ack, ce_n, oe_n;
    logic [15:0] dat;
    logic [23:1] sadr;
    assign ack  = sel ? if0.ack_o      : if2.ack_o;
    assign dat  = sel ? if0.dat_o      : if2.dat_o;
    assign ce_n = sel ? if0.sram_ce_no : if2.sram_ce_no;
    assign oe_n = sel ? if0.sram_oe_no : if2.sram_oe_no;
    assign sadr = sel ? if0.sram_adr_o : if2.sram_adr_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cnt <= cnt + 1;

    // Every ack seen: which rising edge raised it, and the word presented.
    int          ack_t[$];
    logic [15:0] ack_d[$];
    always @(negedge clk) begin
        if (ack === 1'b1) begin
            ack_t.push_back(cnt);
            ack_d.push_back(dat);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int ws_of();
        return sel ? 0 : 2;
    endfunction

    function automatic int period_of();
`ifdef VIDEO_FETCH_PREDICT_EN
        return ws_of() + 2;
`else
        return ws_of() + 3;
`endif
    endfunction

    // Fetch n words starting at start; word jump_at (if < n) comes from jump_adr
    // instead of the next sequential address. Checks ack edges and data.
    task automatic burst(input logic [23:1] start, input int n, input int jump_at,
                         input logic [23:1] jump_adr, input bit rel);
        int          exp_t[$];
        logic [23:1] exp_a[$];
        logic [23:1] a;
        int          t, t0, got, guard;
        ack_t.delete();
        ack_d.delete();
        @(negedge clk);
        cyc = 1'b1;
        adr = start;
        if (rel) reset_ni = 1'b1;
        t0 = cnt + 1;
        // Reference: first ack WS+1 edges after sampling; steady period after that,
        // but any non-sequential address costs a full IDLE-style period.
        a = start;
        t = t0 + ws_of() + 1;
        for (int k = 0; k < n; k++) begin
            if (k == jump_at) a = jump_adr;
            if (k > 0) t += (k == jump_at) ? ws_of() + 3 : period_of();
            exp_a.push_back(a);
            exp_t.push_back(t);
            a = a + 23'd1;
        end
        got   = 0;
        guard = 0;
        while (got < n && guard < 300) begin
            @(posedge clk); #1;
            guard++;
            if (ack === 1'b1) begin
                got++;
                @(posedge clk); #1;
                if (got < n) adr = exp_a[got];
                else         cyc = 1'b0;
            end
        end
        chk("burst_ack_count_bound", got, n);
        repeat (ws_of() + 6) @(posedge clk);
        @(negedge clk);
        chk("burst_ack_total", ack_t.size(), n);
        for (int k = 0; k < n && k < ack_t.size(); k++) begin
            chk("ack_edge", ack_t[k], exp_t[k]);
            chk("ack_data", {16'd0, ack_d[k]}, {16'd0, exp_a[k][16:1]});
        end
        chk("idle_ce_n", ce_n, 1'b1);
        chk("idle_oe_n", oe_n, 1'b1);
    endtask

    initial begin
        logic [23:1] r;
        int          n, j;
        total    = 0;
        bad      = 0;
        cnt      = 0;
        sel      = 1'b0;
        cyc      = 1'b1;
        adr      = 23'h000100;
        reset_ni = 1'b0;

        // Reset held with cyc_i asserted: nothing may start.
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_ack",  ack,  1'b0);
        chk("rst_ce_n", ce_n, 1'b1);
        chk("rst_oe_n", oe_n, 1'b1);
        chk("rst_sadr", sadr, 23'h0);
        chk("rst_dat",  dat,  16'h0);

        // Release into a 4-word burst from 0x000100.
        burst(23'h000100, 4, 99, 23'h0, 1'b1);

        // Vsync-style reload to 0x000000 after the second word.
        burst(23'h000200, 4, 2, 23'h000000, 1'b0);

        // Abort mid-ACCESS: no ack, strobes released, then a clean restart.
        ack_t.delete();
        @(negedge clk);
        cyc = 1'b1;
        adr = 23'h000055;
        repeat (2) @(negedge clk);
        cyc = 1'b0;
        @(negedge clk);
        chk("abort_ce_n", ce_n, 1'b1);
        chk("abort_oe_n", oe_n, 1'b1);
        repeat (6) @(negedge clk);
        chk("abort_no_ack", ack_t.size(), 0);
        burst(23'h000077, 1, 99, 23'h0, 1'b0);

        // Zero wait states.
        sel = 1'b1;
        burst(23'h000300, 2, 99, 23'h0, 1'b0);
        burst(23'h7FFFFE, 3, 99, 23'h0, 1'b0);     // address wraps to 0
        burst(23'h001000, 3, 1, 23'h000000, 1'b0);

        // Random bursts on both instances.
        for (int i = 0; i < 6; i++) begin
            sel = i[0];
            r   = 23'($urandom);
            n   = $urandom_range(1, 5);
            j   = $urandom_range(1, 6);
            burst(r, n, j, (r + 23'(j)) ^ 23'h400000, 1'b0);
        end

        // Asynchronous reset between edges in the middle of an access.
        sel = 1'b0;
        ack_t.delete();
        @(negedge clk);
        cyc = 1'b1;
        adr = 23'h001234;
        @(posedge clk);
        @(posedge clk);
        #2 reset_ni = 1'b0;
        #1;
        chk("arst_ack",  ack,  1'b0);
        chk("arst_ce_n", ce_n, 1'b1);
        chk("arst_oe_n", oe_n, 1'b1);
        chk("arst_sadr", sadr, 23'h0);
        chk("arst_dat",  dat,  16'h0);
        cyc = 1'b0;
        @(negedge clk);
        reset_ni = 1'b1;
        repeat (10) @(negedge clk);
        chk("arst_no_ack", ack_t.size(), 0);
        burst(23'h000400, 2, 99, 23'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
